// File: rtl/imc_frame_tx.sv
// Single-wire frame transmitter: waits for bus idle, sends start/32 data/stop bits and
// arbitrates bit-by-bit against the wired-AND readback, retrying on lost arbitration.
module imc_frame_tx #(
    parameter int BIT_CLKS  = 100,
    parameter int IDLE_CLKS = 800,
    parameter int MAX_RETRY = 7
) (
    input  logic        clk_100,
    input  logic        RSTn,
    input  logic        enable,
    input  logic        tx_req,
    input  logic [31:0] tx_data,
    input  logic        rx_pin_in,
    output logic        tx_pin_out,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_lost,
    output logic        tx_fail,
    output logic        tx_err
);
    // state     | meaning
    // IDLE      | no frame pending, bus released
    // WAIT_IDLE | frame latched, waiting for bus idle
    // START     | driving start bit (0), checking for bus fault
    // DATA      | shifting 32 data bits LSB first, arbitrating
    // STOP      | driving stop bit (1), readback ignored

    localparam int BW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int IW = $clog2(IDLE_CLKS + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [BW-1:0] BIT_LAST    = BW'(BIT_CLKS - 1);
    localparam logic [BW-1:0] BIT_MID     = BW'(BIT_CLKS / 2);
    localparam logic [IW-1:0] IDLE_MAX    = IW'(IDLE_CLKS);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY + 1);
    localparam logic [31:0]   BAD_BITS    = 32'h8820_8820;

    typedef enum logic [2:0] {IDLE, WAIT_IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] bit_cnt, bit_cnt_nxt;
    logic [4:0]    bit_idx, bit_idx_nxt;
    logic [31:0]   shift_q, shift_nxt;
    logic [31:0]   frame_q, frame_nxt;
    logic [RW-1:0] retry_cnt, retry_nxt;
    logic [IW-1:0] idle_cnt;
    logic          pin_nxt, busy_nxt;
    logic          done_nxt, lost_nxt, fail_nxt, err_nxt;
    logic          bus_idle, bit_end, bit_mid;

    always_ff @(posedge clk_100 or negedge RSTn) begin
        if (!RSTn) begin
            idle_cnt <= '0;
        end else if (!rx_pin_in) begin
            idle_cnt <= '0;
        end else if (idle_cnt < IDLE_MAX) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    assign bus_idle = (idle_cnt >= IDLE_MAX);
    assign bit_end  = (bit_cnt == BIT_LAST);
    assign bit_mid  = (bit_cnt == BIT_MID);

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_q;
        frame_nxt   = frame_q;
        retry_nxt   = retry_cnt;
        pin_nxt     = 1'b1;
        busy_nxt    = tx_busy;
        done_nxt    = 1'b0;
        lost_nxt    = 1'b0;
        fail_nxt    = 1'b0;
        err_nxt     = 1'b0;

        if (!enable) begin
            state_nxt   = IDLE;
            busy_nxt    = 1'b0;
            retry_nxt   = '0;
            bit_cnt_nxt = '0;
            bit_idx_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt_nxt = '0;
                    if (tx_req) begin
                        if ((tx_data & BAD_BITS) != 32'd0) begin
                            err_nxt = 1'b1;
                        end else begin
                            frame_nxt = tx_data;
                            busy_nxt  = 1'b1;
                            state_nxt = WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (bus_idle) begin
                        state_nxt   = START;
                        bit_cnt_nxt = '0;
                        shift_nxt   = frame_q;
                        pin_nxt     = 1'b0;
                    end
                end
                START: begin
                    pin_nxt = 1'b0;
                    // Readback high while we pull low means the line is stuck or shorted.
                    if (bit_mid && rx_pin_in) begin
                        fail_nxt    = 1'b1;
                        state_nxt   = IDLE;
                        busy_nxt    = 1'b0;
                        retry_nxt   = '0;
                        bit_cnt_nxt = '0;
                        pin_nxt     = 1'b1;
                    end else if (bit_end) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                        bit_idx_nxt = '0;
                        pin_nxt     = shift_q[0];
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
                DATA: begin
                    pin_nxt = shift_q[0];
                    if (bit_mid && shift_q[0] && !rx_pin_in) begin
                        pin_nxt     = 1'b1;
                        bit_cnt_nxt = '0;
                        if ((retry_cnt + RW'(1)) == RETRY_LIMIT) begin
                            fail_nxt  = 1'b1;
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                            retry_nxt = '0;
                        end else begin
                            lost_nxt  = 1'b1;
                            retry_nxt = retry_cnt + RW'(1);
                            state_nxt = WAIT_IDLE;
                        end
                    end else if (bit_end) begin
                        bit_cnt_nxt = '0;
                        shift_nxt   = shift_q >> 1;
                        if (bit_idx == 5'd31) begin
                            state_nxt = STOP;
                            pin_nxt   = 1'b1;
                        end else begin
                            bit_idx_nxt = bit_idx + 5'd1;
                            pin_nxt     = shift_q[1];
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        done_nxt    = 1'b1;
                        state_nxt   = IDLE;
                        busy_nxt    = 1'b0;
                        retry_nxt   = '0;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100 or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            frame_q    <= '0;
            retry_cnt  <= '0;
            tx_pin_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_lost    <= 1'b0;
            tx_fail    <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift_q    <= shift_nxt;
            frame_q    <= frame_nxt;
            retry_cnt  <= retry_nxt;
            tx_pin_out <= pin_nxt;
            tx_busy    <= busy_nxt;
            tx_done    <= done_nxt;
            tx_lost    <= lost_nxt;
            tx_fail    <= fail_nxt;
            tx_err     <= err_nxt;
        end
    end
endmodule

// File: tb/tb_imc_frame_tx.sv
// Bench for imc_frame_tx: transaction-level outcome model feeds an expectation queue,
// a negedge monitor decodes the line and checks every status pulse against it.
module tb_imc_frame_tx;
    localparam int BIT_CLKS  = 100;
    localparam int IDLE_CLKS = 800;
    localparam int MAX_RETRY = 7;
    localparam int FRAME_BITS = 34;
    localparam logic [31:0] BAD_BITS = (32'd1 << 5) | (32'd1 << 11) | (32'd1 << 15) |
                                       (32'd1 << 21) | (32'd1 << 27) | (32'd1 << 31);

    typedef enum int {EV_DONE = 0, EV_LOST = 1, EV_FAIL = 2, EV_ERR = 3} ev_t;
    typedef struct {
        ev_t         kind;
        logic [31:0] word;
    } exp_t;

    logic        clk_100 = 1'b0;
    logic        RSTn = 1'b0;
    logic        enable = 1'b0;
    logic        tx_req = 1'b0;
    logic [31:0] tx_data = '0;
    logic        other_drv = 1'b1;
    logic        stuck_high = 1'b0;
    logic        rx_pin_in;
    logic        tx_pin_out, tx_busy, tx_done, tx_lost, tx_fail, tx_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int f_start = 0;
    int wait_begin = 0;
    int hi_run = 0;
    int start_cnt = 0;
    logic        in_frame = 1'b0;
    logic        prev_pin = 1'b1;
    logic        prev_busy = 1'b0;
    logic [33:0] bits = '0;
    exp_t        exp_q[$];

    assign rx_pin_in = stuck_high | (tx_pin_out & other_drv);

    imc_frame_tx #(.BIT_CLKS(BIT_CLKS), .IDLE_CLKS(IDLE_CLKS), .MAX_RETRY(MAX_RETRY)) dut (
        .clk_100(clk_100), .RSTn(RSTn), .enable(enable), .tx_req(tx_req), .tx_data(tx_data),
        .rx_pin_in(rx_pin_in), .tx_pin_out(tx_pin_out), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_lost(tx_lost), .tx_fail(tx_fail), .tx_err(tx_err)
    );

    always #5 clk_100 = ~clk_100;
    always @(posedge clk_100) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: frame decode, idle-gap rule and pulse scoreboard.
    always @(negedge clk_100) begin
        logic [3:0] pulses;
        int d;
        ev_t seen;
        exp_t e;
        if (!RSTn) begin
            in_frame  = 1'b0;
            hi_run    = 0;
            prev_pin  = 1'b1;
            prev_busy = 1'b0;
        end else begin
            pulses = {tx_err, tx_fail, tx_lost, tx_done};
            if (!prev_busy && tx_busy) wait_begin = cyc;
            if (!in_frame && tx_busy && prev_pin && !tx_pin_out) begin
                in_frame = 1'b1;
                f_start  = cyc;
                start_cnt++;
                chk("start_after_idle",
                    64'((hi_run >= IDLE_CLKS + 1) &&
                        ((cyc - wait_begin == 1) || (hi_run == IDLE_CLKS + 1))), 64'd1);
            end
            if (in_frame) begin
                d = cyc - f_start;
                if ((d % BIT_CLKS) == BIT_CLKS / 2 && (d / BIT_CLKS) < FRAME_BITS)
                    bits[d / BIT_CLKS] = tx_pin_out;
            end
            if (pulses != 4'd0) begin
                chk("one_pulse", 64'($countones(pulses)), 64'd1);
                chk("pin_released_at_pulse", 64'(tx_pin_out), 64'd1);
                seen = tx_done ? EV_DONE : tx_lost ? EV_LOST : tx_fail ? EV_FAIL : EV_ERR;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 64'(int'(seen)), 64'hFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 64'(int'(seen)), 64'(int'(e.kind)));
                    if (seen == EV_LOST) begin
                        chk("busy_after_lost", 64'(tx_busy), 64'd1);
                        wait_begin = cyc;
                    end else begin
                        chk("busy_cleared", 64'(tx_busy), 64'd0);
                    end
                    if (seen == EV_DONE && e.kind == EV_DONE) begin
                        chk("frame_bits", 64'(bits), 64'({1'b1, e.word, 1'b0}));
                        chk("frame_length", 64'(cyc - f_start), 64'(FRAME_BITS * BIT_CLKS));
                    end
                end
                in_frame = 1'b0;
            end
            if (!tx_busy) in_frame = 1'b0;
            hi_run    = rx_pin_in ? hi_run + 1 : 0;
            prev_pin  = tx_pin_out;
            prev_busy = tx_busy;
        end
    end

    task automatic wait_start(input int prev);
        int n = 0;
        while (start_cnt == prev && n < 3000) begin
            @(negedge clk_100);
            #1;
            n++;
        end
        chk("start_seen", 64'(start_cnt != prev), 64'd1);
    endtask

    // Called at negedge+1; returns just after edge f_start+offset.
    task automatic goto_offset(input int offset);
        int n;
        n = f_start + offset - cyc;
        repeat (n) @(posedge clk_100);
        #1;
    endtask

    function automatic int pick_one(input logic [31:0] w);
        logic [31:0] v;
        int idx;
        v = w;
        idx = $urandom_range(31, 0);
        while (!v[idx]) idx = (idx + 1) % 32;
        return idx;
    endfunction

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 20000) begin
            @(posedge clk_100);
            #1;
            n++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // amode: 0 normal, 1 enable drop at data bit 10, 2 reset at data bit 20,
    //        3 stuck-high readback during start, 4 normal plus tx_req while busy
    task automatic run_txn(input logic [31:0] w, input int nloss, input int amode);
        int prev;
        int n;
        logic bad;
        logic ok;
        bad = (w & BAD_BITS) != 32'd0;
        if (bad) exp_q.push_back('{kind: EV_ERR, word: w});
        else if (amode == 3) exp_q.push_back('{kind: EV_FAIL, word: w});
        else if (amode == 0 || amode == 4) begin
            for (int i = 0; i < nloss && i < MAX_RETRY; i++) exp_q.push_back('{kind: EV_LOST, word: w});
            exp_q.push_back('{kind: (nloss > MAX_RETRY) ? EV_FAIL : EV_DONE, word: w});
        end
        n = 0;
        while (tx_busy && n < 10000) begin
            @(posedge clk_100);
            #1;
            n++;
        end
        prev = start_cnt;
        tx_data = w;
        tx_req  = 1'b1;
        @(posedge clk_100);
        #1;
        tx_req = 1'b0;
        if (bad) begin
            ok = 1'b1;
            for (int i = 0; i < 20; i++) begin
                if (tx_busy || !tx_pin_out) ok = 1'b0;
                @(posedge clk_100);
                #1;
            end
            chk("err_no_activity", 64'(ok), 64'd1);
        end else begin
            for (int a = 0; a < nloss && a <= MAX_RETRY; a++) begin
                wait_start(prev);
                prev = start_cnt;
                goto_offset(BIT_CLKS * (pick_one(w) + 1) + BIT_CLKS / 2);
                other_drv = 1'b0;
                @(posedge clk_100);
                #1;
                other_drv = 1'b1;
            end
            if (amode != 0) wait_start(prev);
            if (amode == 1) begin
                goto_offset(BIT_CLKS * 11 + 20);
                enable = 1'b0;
                @(posedge clk_100);
                @(negedge clk_100);
                chk("enable_drop_pin", 64'(tx_pin_out), 64'd1);
                chk("enable_drop_busy", 64'(tx_busy), 64'd0);
                repeat (3) @(posedge clk_100);
                #1;
                enable = 1'b1;
            end else if (amode == 2) begin
                goto_offset(BIT_CLKS * 21 + 30);
                RSTn = 1'b0;
                #1;
                chk("reset_async_pin", 64'(tx_pin_out), 64'd1);
                chk("reset_async_busy", 64'(tx_busy), 64'd0);
                repeat (3) @(posedge clk_100);
                #2;
                RSTn = 1'b1;
                repeat (1000) @(posedge clk_100);
                #1;
                chk("no_resend_after_reset", 64'({tx_busy, tx_pin_out}), 64'b01);
            end else if (amode == 3) begin
                goto_offset(BIT_CLKS / 2);
                stuck_high = 1'b1;
                @(posedge clk_100);
                #1;
                stuck_high = 1'b0;
            end else if (amode == 4) begin
                goto_offset(500);
                tx_data = 32'h0000_0020;
                tx_req  = 1'b1;
                @(posedge clk_100);
                #1;
                tx_req  = 1'b0;
                tx_data = w;
            end
        end
        drain();
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        repeat (3) @(posedge clk_100);
        #1;
        chk("reset_pin", 64'(tx_pin_out), 64'd1);
        chk("reset_busy", 64'(tx_busy), 64'd0);
        chk("reset_pulses", 64'({tx_done, tx_lost, tx_fail, tx_err}), 64'd0);
        #2;
        RSTn   = 1'b1;
        enable = 1'b1;
        repeat (1000) @(posedge clk_100);
        #1;

        run_txn(32'h0000_0004, 0, 4);
        run_txn(32'h0000_0020, 0, 0);
        run_txn(32'h8000_0001, 0, 0);
        run_txn(32'h0000_0004, 1, 0);
        run_txn(32'h0000_0004, MAX_RETRY + 1, 0);
        run_txn(32'h0505_0404, 0, 1);
        run_txn(32'h0505_0404, 0, 0);
        run_txn(32'h0000_0003, 0, 2);
        run_txn(32'h4000_0006, 0, 0);
        run_txn(32'h0000_0001, 0, 3);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            if ($urandom_range(3, 0) != 0) w = w & ~BAD_BITS;
            if (w == 32'd0) w = 32'd1;
            run_txn(w, int'($urandom_range(2, 0)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imc_frame_tx.md
IMC_FRAME_TX -- requirements
Module: imc_frame_tx

Interface
REQ-001 SHALL have parameter BIT_CLKS, default 100, clk_100 cycles per bit (1 Mbps).
REQ-002 SHALL have parameter IDLE_CLKS, default 800, consecutive high cycles that define bus idle.
REQ-003 SHALL have parameter MAX_RETRY, default 7, arbitration losses tolerated before giving up.
REQ-004 SHALL have port clk_100  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  block enable; low aborts and holds idle.
REQ-007 SHALL have port tx_req  input  1  send request, sampled only while tx_busy=0.
REQ-008 SHALL have port tx_data  input  32  frame word, latched on accepted tx_req.
REQ-009 SHALL have port rx_pin_in  input  1  bus readback (wired-AND, idle high).
REQ-010 SHALL have port tx_pin_out  output  1  bus drive, 1 = released/recessive.
REQ-011 SHALL have port tx_busy  output  1  high from accept until done/fail/abort.
REQ-012 SHALL have ports tx_done, tx_lost, tx_fail, tx_err  output  1 each  single-cycle status pulses.

Function
REQ-013 SHALL implement states IDLE, WAIT_IDLE, START, DATA, STOP.
REQ-014 SHALL, in IDLE with enable=1 and tx_req=1, latch tx_data, set tx_busy=1 next cycle, enter WAIT_IDLE; tx_req while busy ignored.
REQ-015 SHALL reject accepted words having any of bits 5,11,15,21,27,31 set: tx_err pulse, stay IDLE, tx_busy stays 0.
REQ-016 SHALL run a saturating idle counter continuously: +1 per cycle rx_pin_in=1, cleared on rx_pin_in=0; bus idle when count >= IDLE_CLKS.
REQ-017 SHALL leave WAIT_IDLE the cycle after bus idle is seen, driving tx_pin_out=0 from the first START cycle.
REQ-018 SHALL hold every bit (start, data, stop) exactly BIT_CLKS cycles using a bit-cycle counter 0..BIT_CLKS-1.
REQ-019 SHALL frame as: start bit 0, 32 data bits LSB first (tx_data[0] first), stop bit 1; total 34*BIT_CLKS cycles.
REQ-020 SHALL sample rx_pin_in at bit-cycle count BIT_CLKS/2 of each start and data bit.
REQ-021 SHALL, in DATA, on driven 1 but sampled 0 (arbitration loss): tx_pin_out=1 next cycle, tx_lost pulse, retry_cnt+1, return to WAIT_IDLE.
REQ-022 SHALL, when an arbitration loss makes retry_cnt equal MAX_RETRY+1, pulse tx_fail instead of retrying, clear tx_busy and retry_cnt, go IDLE.
REQ-023 SHALL, in START, on sampled 1 while driving 0 (bus fault): release bus, pulse tx_fail, clear tx_busy, go IDLE.
REQ-024 SHALL, at end of STOP, pulse tx_done, clear tx_busy and retry_cnt, go IDLE in the same cycle; earliest next accept one cycle later.
REQ-025 SHALL, on enable=0 in any state: tx_pin_out=1 and IDLE next cycle, tx_busy=0, no pulse; retry_cnt cleared.
REQ-026 SHALL ignore rx_pin_in mismatches during STOP (driving 1).
REQ-027 SHALL never assert more than one status pulse in the same cycle.

Reset
REQ-028 SHALL, while RSTn=0: tx_pin_out=1, tx_busy=0, all pulses 0, state IDLE, idle counter 0, bit counters 0, retry_cnt 0, shift register 0.
REQ-029 SHALL, on RSTn asserted mid-frame, release the bus immediately (asynchronously) and require a fresh tx_req after release.

Verification
REQ-030 Bus held high, tx_req with 32'h0000_0004 -> START after 800 idle cycles, pins LSB first, tx_done exactly 3400 cycles after START begins.
REQ-031 tx_data=32'h0000_0020 -> tx_err pulse, tx_pin_out stays 1, tx_busy stays 0.
REQ-032 Force rx_pin_in=0 at mid of data bit 2 while driving 1 -> tx_lost pulse, bus released next cycle, retransmission starts after 800 idle cycles.
REQ-033 Eight consecutive forced arbitration losses -> seven tx_lost pulses then one tx_fail, tx_busy=0.
REQ-034 Drop enable at data bit 10, and separately pulse RSTn at data bit 20 -> tx_pin_out=1 next cycle/immediately, no tx_done, next tx_req sends full frame.
